// File: rtl/fll_cfg_responder.sv
// Responder end of the FLL_BUS configuration interface. Holds one FLL's
// register set (STATUS/CFG1/CFG2/INTEG), a settling model of the measured
// multiplication factor, and a registered lock flag.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for req_i; captures addr/web/wdata on request
// WAIT  | latency down-counter running; bus inputs ignored
// ACK   | one-cycle ack_o; write commits / read data presented
// DONE  | waiting for req_i to drop before accepting a new access
//
// A latency of 1 spends exactly one cycle in WAIT, so the distance from the
// first cycle req_i is high to the ack cycle is ACK_LATENCY+1 for every
// legal latency.
module fll_cfg_responder #(
  parameter int unsigned ACK_LATENCY = 2,
  parameter logic [31:0] CFG1_RST    = 32'h0000_05F5,
  parameter logic [31:0] CFG2_RST    = 32'h0000_0000,
  parameter logic [31:0] INTEG_RST   = 32'h0000_0000,
  parameter int unsigned LOCK_TOL    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [1:0]  addr_i,
  input  logic        web_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        lock_o,
  output logic [31:0] cfg1_o,
  output logic [31:0] cfg2_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_DONE} state_e;

  localparam logic [3:0]  LAT_LOAD   = 4'(ACK_LATENCY - 1);
  localparam logic [16:0] LOCK_TOL17 = 17'(LOCK_TOL);

  state_e      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [1:0]  addr_q, addr_d;
  logic        web_q, web_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cfg1_q, cfg1_d;
  logic [31:0] cfg2_q, cfg2_d;
  logic [31:0] integ_q, integ_d;
  logic [15:0] cnt_q, cnt_d;
  logic        lock_q, lock_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] integ_rd;
  logic [31:0] rd_mux;
  logic [16:0] diff;

  // Read-side view of the register file, sampled in the ACK cycle.
  always_comb begin
    integ_rd = integ_q;
    if (cfg1_q[31]) integ_rd[25:16] = cnt_q[9:0];
    case (addr_q)
      2'd0:    rd_mux = {16'h0000, cnt_q};
      2'd1:    rd_mux = cfg1_q;
      2'd2:    rd_mux = cfg2_q;
      default: rd_mux = integ_rd;
    endcase
  end

  // Access FSM: request capture, latency countdown, ack, release handshake.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    web_d   = web_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          web_d   = web_i;
          wdata_d = wdata_i;
          lat_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == 4'd0) state_d = ST_ACK;
        else               lat_d   = lat_q - 4'd1;
      end
      ST_ACK:  state_d = ST_DONE;
      default: begin
        if (!req_i) state_d = ST_IDLE;
      end
    endcase
  end

  assign ack_o = (state_q == ST_ACK);

  // Register commit on write acks; read data captured on read acks.
  always_comb begin
    cfg1_d  = cfg1_q;
    cfg2_d  = cfg2_q;
    integ_d = integ_q;
    rdata_d = rdata_q;
    if (ack_o) begin
      if (web_q) begin
        rdata_d = rd_mux;
      end else begin
        case (addr_q)
          2'd0:    ;
          2'd1:    cfg1_d  = wdata_q;
          2'd2:    cfg2_d  = wdata_q;
          default: integ_d = wdata_q;
        endcase
      end
    end
  end

  // Settling model and lock; lock is evaluated on next-state values so that
  // lock_o always matches the registers visible in the same cycle.
  always_comb begin
    if (cfg1_q[31]) begin
      if (cnt_q < cfg1_q[15:0])      cnt_d = cnt_q + 16'd1;
      else if (cnt_q > cfg1_q[15:0]) cnt_d = cnt_q - 16'd1;
      else                           cnt_d = cnt_q;
    end else begin
      cnt_d = {6'b000000, cfg1_q[25:16]};
    end
    if (cfg1_d[15:0] >= cnt_d) diff = {1'b0, cfg1_d[15:0]} - {1'b0, cnt_d};
    else                       diff = {1'b0, cnt_d} - {1'b0, cfg1_d[15:0]};
    lock_d = cfg1_d[31] && (diff <= LOCK_TOL17);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      lat_q   <= 4'd0;
      addr_q  <= 2'd0;
      web_q   <= 1'b0;
      wdata_q <= 32'h0;
      cfg1_q  <= CFG1_RST;
      cfg2_q  <= CFG2_RST;
      integ_q <= INTEG_RST;
      cnt_q   <= 16'h0;
      lock_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      web_q   <= web_d;
      wdata_q <= wdata_d;
      cfg1_q  <= cfg1_d;
      cfg2_q  <= cfg2_d;
      integ_q <= integ_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_d;
  assign lock_o  = lock_q;
  assign cfg1_o  = cfg1_q;
  assign cfg2_o  = cfg2_q;

endmodule

// File: tb/tb_fll_cfg_responder.sv
// Bench for fll_cfg_responder: directed bus accesses, a behavioural register /
// settling model checked every cycle, and literal expectations from hand math.
module tb_fll_cfg_responder;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        web = 1'b1;
  logic [31:0] wdata = 32'h0;
  logic        ack_o, lock_o;
  logic [31:0] rdata_o, cfg1_o, cfg2_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_ack_cyc = -1;
  logic        exp_web = 1'b1;
  logic [1:0]  exp_addr = 2'd0;
  logic [31:0] exp_wdata = 32'h0;

  logic [31:0] m_cfg1, m_cfg2, m_integ, m_rdata;
  logic [15:0] m_cnt;

  fll_cfg_responder #(.ACK_LATENCY(L)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .web_i(web),
    .wdata_i(wdata), .ack_o(ack_o), .rdata_o(rdata_o), .lock_o(lock_o),
    .cfg1_o(cfg1_o), .cfg2_o(cfg2_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] v;
    case (a)
      2'd0: v = {16'h0, m_cnt};
      2'd1: v = m_cfg1;
      2'd2: v = m_cfg2;
      default: begin
        v = m_integ;
        if (m_cfg1[31]) v = {m_integ[31:26], m_cnt[9:0], m_integ[15:0]};
      end
    endcase
    return v;
  endfunction

  function automatic logic model_lock();
    int d;
    d = int'(m_cfg1[15:0]) - int'(m_cnt);
    if (d < 0) d = -d;
    return m_cfg1[31] && (d <= 4);
  endfunction

  // Behavioural model: settle, commit the acked write, remember last read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_cfg1  <= 32'h0000_05F5;
      m_cfg2  <= 32'h0;
      m_integ <= 32'h0;
      m_cnt   <= 16'h0;
      m_rdata <= 32'h0;
    end else begin
      if (m_cfg1[31]) begin
        if (m_cnt < m_cfg1[15:0])      m_cnt <= m_cnt + 16'd1;
        else if (m_cnt > m_cfg1[15:0]) m_cnt <= m_cnt - 16'd1;
      end else begin
        m_cnt <= {6'd0, m_cfg1[25:16]};
      end
      if (cyc == exp_ack_cyc) begin
        if (exp_web) m_rdata <= model_read(exp_addr);
        else begin
          case (exp_addr)
            2'd1: m_cfg1  <= exp_wdata;
            2'd2: m_cfg2  <= exp_wdata;
            2'd3: m_integ <= exp_wdata;
            default: ;
          endcase
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic ea;
    ea = (cyc == exp_ack_cyc);
    chk("ack_o", {31'd0, ack_o}, {31'd0, ea});
    chk("rdata_o", rdata_o, (ea && exp_web) ? model_read(exp_addr) : m_rdata);
    chk("lock_o", {31'd0, lock_o}, {31'd0, model_lock()});
    chk("cfg1_o", cfg1_o, m_cfg1);
    chk("cfg2_o", cfg2_o, m_cfg2);
  end

  task automatic bus(input logic rd, input logic [1:0] a, input logic [31:0] d,
                     input int hold, output logic [31:0] rval, output int lat,
                     output int ack_cyc, output int extra);
    int rise;
    bit got;
    @(negedge clk);
    req = 1'b1; addr = a; web = rd; wdata = d;
    exp_web = rd; exp_addr = a; exp_wdata = d;
    rise = cyc;
    exp_ack_cyc = cyc + L + 1;
    got = 0; extra = 0; rval = 32'h0; lat = -1; ack_cyc = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ack_o) got = 1;
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      req = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      rval = rdata_o;
      lat = cyc - rise;
      ack_cyc = cyc;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (ack_o) extra++;
      end
      req = 1'b0;
      if (hold == 0) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rv;
    int lat, ack_c, extra, wr_ack, acks;
    bit seen;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset values and first read latency
    chk("rst_lock", {31'd0, lock_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'h0);
    bus(1'b1, 2'd1, 32'h0, 0, rv, lat, ack_c, extra);
    chk("rd_cfg1_rst", rv, 32'h0000_05F5);
    chk("ack_latency", lat, 32'd3);

    // Closed loop toward target 16
    bus(1'b0, 2'd1, 32'h8000_0010, 0, rv, lat, wr_ack, extra);
    bus(1'b1, 2'd0, 32'h0, 0, rv, lat, ack_c, extra);
    chk("status_early", rv, 32'h0000_0004);
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (lock_o) seen = 1;
      else @(negedge clk);
    end
    chk("lock_rise_cycle", cyc - wr_ack, 32'd13);
    repeat (10) @(negedge clk);
    bus(1'b1, 2'd0, 32'h0, 0, rv, lat, ack_c, extra);
    chk("status_settled", rv, 32'h0000_0010);
    bus(1'b1, 2'd3, 32'h0, 0, rv, lat, ack_c, extra);
    chk("integ_closed", rv, 32'h0010_0000);

    // Open loop
    bus(1'b0, 2'd1, 32'h0003_0A73, 0, rv, lat, ack_c, extra);
    chk("lock_open", {31'd0, lock_o}, 32'd0);
    chk("cfg1_o_open", cfg1_o, 32'h0003_0A73);
    bus(1'b1, 2'd0, 32'h0, 0, rv, lat, ack_c, extra);
    chk("status_open", rv, 32'h0000_0003);
    bus(1'b1, 2'd1, 32'h0, 0, rv, lat, ack_c, extra);
    chk("rd_cfg1_open", rv, 32'h0003_0A73);
    bus(1'b1, 2'd3, 32'h0, 0, rv, lat, ack_c, extra);
    chk("integ_open", rv, 32'h0);

    // STATUS is read-only; CFG2 and INTEG read back
    bus(1'b0, 2'd0, 32'hDEAD_BEEF, 0, rv, lat, ack_c, extra);
    chk("status_wr_lat", lat, 32'd3);
    bus(1'b1, 2'd0, 32'h0, 0, rv, lat, ack_c, extra);
    chk("status_ro", rv, 32'h0000_0003);
    bus(1'b0, 2'd2, 32'h1234_5678, 0, rv, lat, ack_c, extra);
    chk("cfg2_o", cfg2_o, 32'h1234_5678);
    bus(1'b1, 2'd2, 32'h0, 0, rv, lat, ack_c, extra);
    chk("rd_cfg2", rv, 32'h1234_5678);
    bus(1'b0, 2'd3, 32'hABCD_1234, 0, rv, lat, ack_c, extra);
    bus(1'b1, 2'd3, 32'h0, 0, rv, lat, ack_c, extra);
    chk("rd_integ", rv, 32'hABCD_1234);

    // req held past ack, then re-request after a single low cycle
    bus(1'b1, 2'd2, 32'h0, 5, rv, lat, ack_c, extra);
    chk("hold_extra_acks", extra, 32'd0);
    chk("hold_rdata", rv, 32'h1234_5678);
    bus(1'b1, 2'd1, 32'h0, 0, rv, lat, ack_c, extra);
    chk("after_hold_lat", lat, 32'd3);
    chk("after_hold_rdata", rv, 32'h0003_0A73);

    // Reset during WAIT of a CFG2 write
    @(negedge clk);
    req = 1'b1; addr = 2'd2; web = 1'b0; wdata = 32'hFFFF_FFFF;
    exp_web = 1'b0; exp_addr = 2'd2; exp_wdata = 32'hFFFF_FFFF;
    exp_ack_cyc = cyc + L + 1;
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0; exp_ack_cyc = -1;
    acks = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (ack_o) acks++;
    end
    chk("abort_no_ack", acks, 32'd0);
    rst_n = 1'b1;
    bus(1'b1, 2'd2, 32'h0, 0, rv, lat, ack_c, extra);
    chk("abort_cfg2", rv, 32'h0);
    bus(1'b1, 2'd1, 32'h0, 0, rv, lat, ack_c, extra);
    chk("abort_cfg1", rv, 32'h0000_05F5);
    chk("abort_lock", {31'd0, lock_o}, 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
